// File: rtl/manchester_txd.sv
`timescale 1ns/1ps
// manchester_txd: serializes bytes LSB-first and Manchester-encodes them onto
// the line, with back-to-back byte streaming and an idle-high end-of-frame tail.
//
// Ports
//   clk    in   system clock
//   reset  in   asynchronous active-high reset
//   data   in   [7:0] byte to send, sampled only at a load point
//   valid  in   a byte is available on data, sampled at load points
//   rdy    out  one-cycle pulse: data was just latched
//   txd    out  Manchester-encoded serial line (0 = high-low, 1 = low-high)
//   txen   out  high while a frame, including the EOF tail, is on the line
module manchester_txd #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BIT_RATE = 50_000,
  parameter int unsigned EOF_BITS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       rdy,
  output logic       txd,
  output logic       txen
);

  localparam int unsigned HALF       = CLK_FREQ / (2 * BIT_RATE);
  localparam int unsigned HCW        = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned EOF_HALVES = 2 * EOF_BITS;
  localparam int unsigned ECW        = (EOF_HALVES > 1) ? $clog2(EOF_HALVES) : 1;

  // Parameter sanity checks at elaboration
  generate
    if (HALF < 2) begin : g_half_check
      $error("manchester_txd: CLK_FREQ/(2*BIT_RATE) must be at least 2");
    end
    if (EOF_BITS < 1) begin : g_eof_check
      $error("manchester_txd: EOF_BITS must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_EOF  = 2'd2
  } state_t;

  state_t          state;
  logic [7:0]      shreg;
  logic [HCW-1:0]  half_cnt;
  logic [3:0]      bit_cnt;
  logic [ECW-1:0]  eof_cnt;
  logic            half_last;
  logic            eof_last;

  assign half_last = (half_cnt == HCW'(HALF - 1));
  assign eof_last  = (eof_cnt == ECW'(EOF_HALVES - 1));

  // Framing FSM; outputs are registered alongside the state they belong to
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      shreg    <= 8'd0;
      half_cnt <= '0;
      bit_cnt  <= 4'd0;
      eof_cnt  <= '0;
      rdy      <= 1'b0;
      txd      <= 1'b1;
      txen     <= 1'b0;
    end else begin
      rdy <= 1'b0;
      case (state)
        S_IDLE: begin
          txd  <= 1'b1;
          txen <= 1'b0;
          if (valid) begin
            state    <= S_SEND;
            shreg    <= data;
            half_cnt <= '0;
            bit_cnt  <= 4'd0;
            rdy      <= 1'b1;
            txen     <= 1'b1;
            txd      <= ~data[0];
          end
        end

        S_SEND: begin
          if (half_last) begin
            half_cnt <= '0;
            bit_cnt  <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) begin
              // Byte boundary: chain the next byte or start the tail
              if (valid) begin
                shreg <= data;
                rdy   <= 1'b1;
                txd   <= ~data[0];
              end else begin
                state   <= S_EOF;
                eof_cnt <= '0;
                txd     <= 1'b1;
              end
            end else if (!bit_cnt[0]) begin
              // First half done: present the true bit value
              txd <= shreg[0];
            end else begin
              // Whole bit done: advance to the next bit's first half
              shreg <= {1'b0, shreg[7:1]};
              txd   <= ~shreg[1];
            end
          end else begin
            half_cnt <= half_cnt + HCW'(1);
          end
        end

        S_EOF: begin
          txd <= 1'b1;
          if (half_last) begin
            half_cnt <= '0;
            if (eof_last) begin
              state   <= S_IDLE;
              eof_cnt <= '0;
              txen    <= 1'b0;
            end else begin
              eof_cnt <= eof_cnt + ECW'(1);
            end
          end else begin
            half_cnt <= half_cnt + HCW'(1);
          end
        end

        default: begin
          state <= S_IDLE;
          txd   <= 1'b1;
          txen  <= 1'b0;
        end
      endcase
    end
  end

endmodule
